// File: rtl/sitcp_tx_pkg.sv
// Shared types and the round-robin pick helper for the SiTCP TCP transmit arbiter.
package sitcp_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        DISCARD = 2'd2,
        CLOSE   = 2'd3
    } tx_state_t;

    // Indices are carried at the width of the largest supported requester count.
    localparam int MAX_SRC = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid index at or after ptr, wrapping at n_src.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_SRC-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 n_src
    );
        rr_pick_t         res;
        int               j;
        logic [IDX_W-1:0] jj;
        res = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= n_src) begin
                j = j - n_src;
            end
            jj = IDX_W'(j);
            if ((k < n_src) && !res.found && valid[jj]) begin
                res.found = 1'b1;
                res.idx   = jj;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sitcp_tx_rr_arb.sv
// Combinational round-robin selector: first valid requester from the pointer upward.
module sitcp_tx_rr_arb
    import sitcp_tx_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_SRC'(valid), ptr, N_SRC);
        found = pick.found;
        idx   = pick.idx;
    end

endmodule

// File: rtl/sitcp_tcp_tx_arbiter.sv
// Packet-granular round-robin sharing of the SiTCP TCP TX byte stream, with
// connection sequencing (discard on disconnect/close, CLOSE_ACK handshake).
module sitcp_tcp_tx_arbiter
    import sitcp_tx_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int TO_US = 1000,
    parameter int CNT_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               TIM_1US,
    input  logic               MAIN_OPEN_ACK,
    input  logic               CLOSE_REQ,
    output logic               CLOSE_ACK,
    input  logic               TX_FULL,
    output logic               TX_WR,
    output logic [7:0]         TX_DATA,
    input  logic [N_SRC-1:0]   SRC_VALID,
    input  logic [N_SRC-1:0]   SRC_LAST,
    input  logic [8*N_SRC-1:0] SRC_DATA,
    output logic [N_SRC-1:0]   SRC_READY,
    output logic [N_SRC-1:0]   GRANT,
    output logic               TO_ERR,
    output logic               DROP_ERR,
    output logic [CNT_W-1:0]   TX_BYTE_CNT
);

    localparam int TO_W = (TO_US > 1) ? $clog2(TO_US) : 1;

    tx_state_t        state_reg;
    logic [IDX_W-1:0] gidx_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [N_SRC-1:0] grant_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             close_ack_reg;
    logic             tx_wr_reg;
    logic [7:0]       tx_data_reg;
    logic             to_err_reg;
    logic             drop_err_reg;
    logic [CNT_W-1:0] byte_cnt_reg;

    logic [MAX_SRC-1:0] valid_ext;
    logic [MAX_SRC-1:0] last_ext;
    logic [7:0]         data_ext [MAX_SRC];

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             ready_g;
    logic             valid_g;
    logic             last_g;
    logic             accept;
    logic             to_tick;
    logic             to_hit;
    logic [IDX_W-1:0] ptr_after;

    assign valid_ext = MAX_SRC'(SRC_VALID);
    assign last_ext  = MAX_SRC'(SRC_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SRC; gi++) begin : g_data
            if (gi < N_SRC) begin : g_used
                assign data_ext[gi] = SRC_DATA[8*gi +: 8];
            end else begin : g_pad
                assign data_ext[gi] = 8'h00;
            end
        end
        for (gi = 0; gi < N_SRC; gi++) begin : g_ready
            assign SRC_READY[gi] = grant_reg[gi] & ready_g;
        end
    endgenerate

    sitcp_tx_rr_arb #(
        .N_SRC(N_SRC)
    ) u_rr_arb (
        .valid(SRC_VALID),
        .ptr  (ptr_reg),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // Discarding drains the owner unconditionally; sending needs an open, non-closing, non-full core.
    always_comb begin
        ready_g = 1'b0;
        case (state_reg)
            SEND:    ready_g = MAIN_OPEN_ACK & ~CLOSE_REQ & ~TX_FULL;
            DISCARD: ready_g = 1'b1;
            default: ready_g = 1'b0;
        endcase
    end

    assign valid_g   = valid_ext[gidx_reg];
    assign last_g    = last_ext[gidx_reg];
    assign accept    = valid_g & ready_g;
    assign to_tick   = TIM_1US & ~valid_g & ~TX_FULL;
    assign to_hit    = to_tick & (to_cnt_reg == TO_W'(TO_US - 1));
    assign ptr_after = (gidx_reg == IDX_W'(N_SRC - 1)) ? '0 : gidx_reg + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            gidx_reg      <= '0;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            to_cnt_reg    <= '0;
            close_ack_reg <= 1'b0;
            tx_wr_reg     <= 1'b0;
            tx_data_reg   <= 8'h00;
            to_err_reg    <= 1'b0;
            drop_err_reg  <= 1'b0;
            byte_cnt_reg  <= '0;
        end else begin
            tx_wr_reg    <= 1'b0;
            to_err_reg   <= 1'b0;
            drop_err_reg <= 1'b0;
            if (tx_wr_reg) begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (CLOSE_REQ) begin
                        state_reg     <= CLOSE;
                        close_ack_reg <= 1'b1;
                    end else if (MAIN_OPEN_ACK && pick_found) begin
                        state_reg  <= SEND;
                        gidx_reg   <= pick_idx;
                        grant_reg  <= N_SRC'(1) << pick_idx;
                        to_cnt_reg <= '0;
                    end
                end

                SEND: begin
                    if (!MAIN_OPEN_ACK || CLOSE_REQ) begin
                        state_reg    <= DISCARD;
                        drop_err_reg <= 1'b1;
                        to_cnt_reg   <= '0;
                    end else if (accept) begin
                        tx_wr_reg   <= 1'b1;
                        tx_data_reg <= data_ext[gidx_reg];
                        to_cnt_reg  <= '0;
                        if (last_g) begin
                            state_reg <= IDLE;
                            grant_reg <= '0;
                            ptr_reg   <= ptr_after;
                        end
                    end else if (to_hit) begin
                        // The stalled source is abandoned mid-packet; it must resync itself.
                        state_reg  <= IDLE;
                        grant_reg  <= '0;
                        ptr_reg    <= ptr_after;
                        to_err_reg <= 1'b1;
                        to_cnt_reg <= '0;
                    end else if (to_tick) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                DISCARD: begin
                    if ((accept && last_g) || (!accept && to_hit)) begin
                        state_reg     <= CLOSE_REQ ? CLOSE : IDLE;
                        close_ack_reg <= CLOSE_REQ;
                        grant_reg     <= '0;
                        ptr_reg       <= ptr_after;
                        to_err_reg    <= !accept;
                        to_cnt_reg    <= '0;
                    end else if (accept) begin
                        to_cnt_reg <= '0;
                    end else if (to_tick) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                CLOSE: begin
                    close_ack_reg <= 1'b1;
                    if (!CLOSE_REQ) begin
                        state_reg     <= IDLE;
                        close_ack_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign CLOSE_ACK   = close_ack_reg;
    assign TX_WR       = tx_wr_reg;
    assign TX_DATA     = tx_data_reg;
    assign GRANT       = grant_reg;
    assign TO_ERR      = to_err_reg;
    assign DROP_ERR    = drop_err_reg;
    assign TX_BYTE_CNT = byte_cnt_reg;

endmodule

// File: tb/tb_sitcp_tcp_tx_arbiter.sv
// Directed self-checking bench for sitcp_tcp_tx_arbiter (4 sources, TO_US=3, 4-bit byte counter).
module tb_sitcp_tcp_tx_arbiter;

    localparam int NS = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          TIM_1US = 1'b0;
    logic          MAIN_OPEN_ACK = 1'b0;
    logic          CLOSE_REQ = 1'b0;
    logic          CLOSE_ACK;
    logic          TX_FULL = 1'b0;
    logic          TX_WR;
    logic [7:0]    TX_DATA;
    logic [NS-1:0] SRC_VALID;
    logic [NS-1:0] SRC_LAST;
    logic [8*NS-1:0] SRC_DATA;
    logic [NS-1:0] SRC_READY;
    logic [NS-1:0] GRANT;
    logic          TO_ERR;
    logic          DROP_ERR;
    logic [3:0]    TX_BYTE_CNT;

    sitcp_tcp_tx_arbiter #(
        .N_SRC(NS),
        .TO_US(3),
        .CNT_W(4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .TIM_1US      (TIM_1US),
        .MAIN_OPEN_ACK(MAIN_OPEN_ACK),
        .CLOSE_REQ    (CLOSE_REQ),
        .CLOSE_ACK    (CLOSE_ACK),
        .TX_FULL      (TX_FULL),
        .TX_WR        (TX_WR),
        .TX_DATA      (TX_DATA),
        .SRC_VALID    (SRC_VALID),
        .SRC_LAST     (SRC_LAST),
        .SRC_DATA     (SRC_DATA),
        .SRC_READY    (SRC_READY),
        .GRANT        (GRANT),
        .TO_ERR       (TO_ERR),
        .DROP_ERR     (DROP_ERR),
        .TX_BYTE_CNT  (TX_BYTE_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    // Source model: per-source byte queues {last, data}
    logic [8:0] src_mem [NS][64];
    int         src_rd [NS];
    int         src_wr [NS];
    logic       src_hold [NS];

    // Observed stream and events
    logic [7:0]    rx_buf [256];
    int            rx_n = 0;
    logic [NS-1:0] glog [32];
    int            g_n = 0;
    int            to_err_n = 0;
    int            drop_n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        logic [8:0] h;
        for (int i = 0; i < NS; i++) begin
            h = (src_rd[i] < 64) ? src_mem[i][src_rd[i]] : 9'h000;
            SRC_VALID[i]        = (src_rd[i] < src_wr[i]) && !src_hold[i];
            SRC_LAST[i]         = h[8];
            SRC_DATA[8*i +: 8]  = h[7:0];
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
            src_hold[i] = 1'b0;
            for (int k = 0; k < 64; k++) src_mem[i][k] = 9'h000;
        end
        drive_sources();
        forever begin
            @(posedge CLK);
            for (int i = 0; i < NS; i++) begin
                if (SRC_VALID[i] && SRC_READY[i]) src_rd[i]++;
            end
            #1;
            drive_sources();
        end
    end

    logic [NS-1:0] g_prev = '0;
    initial begin
        forever begin
            @(negedge CLK);
            if (TX_WR) begin
                $display("tx byte %0d = %02h", rx_n, TX_DATA);
                rx_buf[rx_n] = TX_DATA;
                rx_n++;
            end
            if (TO_ERR) to_err_n++;
            if (DROP_ERR) drop_n++;
            if (GRANT != '0 && GRANT != g_prev && g_n < 32) begin
                glog[g_n] = GRANT;
                g_n++;
            end
            g_prev = GRANT;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_pkt(input int s, input logic [7:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            src_mem[s][src_wr[s]] = {(k == len - 1), 8'(int'(base) + k)};
            src_wr[s]++;
        end
    endtask

    task automatic wait_pop(input int s, input int target, input int lim);
        int k = 0;
        while (src_rd[s] < target && k < lim) begin
            @(negedge CLK);
            k++;
        end
        check("pop wait", 32'(src_rd[s] >= target), 1);
    endtask

    task automatic wait_drain(input int lim);
        int  k = 0;
        bit  busy = 1'b1;
        while (busy && k < lim) begin
            busy = (GRANT != '0);
            for (int i = 0; i < NS; i++) if (src_rd[i] < src_wr[i]) busy = 1'b1;
            if (busy) begin
                @(negedge CLK);
                k++;
            end
        end
        check("drain wait", 32'(!busy), 1);
        tick(3);
    endtask

    int base;
    int r0;
    int wr_full;
    int d0;

    initial begin
        // Reset values
        tick(2);
        check("rst grant", 32'(GRANT), 0);
        check("rst tx_wr", 32'(TX_WR), 0);
        check("rst tx_data", 32'(TX_DATA), 0);
        check("rst close_ack", 32'(CLOSE_ACK), 0);
        check("rst cnt", 32'(TX_BYTE_CNT), 0);
        MAIN_OPEN_ACK = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(2);

        // 1: two simultaneous packets, round robin order
        push_pkt(0, 8'hA0, 3);
        push_pkt(2, 8'hC0, 3);
        wait_drain(100);
        check("t1 rx count", 32'(rx_n), 6);
        for (int k = 0; k < 6; k++)
            check("t1 byte", 32'(rx_buf[k]), (k < 3) ? 32'(8'hA0 + k) : 32'(8'hC0 + k - 3));
        check("t1 grant0", 32'(glog[0]), 32'h1);
        check("t1 grant1", 32'(glog[1]), 32'h4);
        check("t1 cnt", 32'(TX_BYTE_CNT), 6);

        // 2: TX_FULL for 5 cycles mid-packet, source stalls and timer ticks meanwhile
        base = rx_n;
        r0 = src_rd[3];
        push_pkt(3, 8'h30, 5);
        wait_pop(3, r0 + 2, 50);
        TX_FULL = 1'b1;
        TIM_1US = 1'b1;
        src_hold[3] = 1'b1;
        wr_full = 0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            if (TX_WR) wr_full++;
            if (c == 0) check("t2 ready low", 32'(SRC_READY), 0);
        end
        TX_FULL = 1'b0;
        TIM_1US = 1'b0;
        src_hold[3] = 1'b0;
        wait_drain(100);
        check("t2 wr after full", 32'(wr_full <= 1), 1);
        check("t2 rx count", 32'(rx_n - base), 5);
        for (int k = 0; k < 5; k++)
            check("t2 byte", 32'(rx_buf[base + k]), 32'(8'h30 + k));
        check("t2 no timeout", 32'(to_err_n), 0);
        check("t2 cnt", 32'(TX_BYTE_CNT), 11);

        // 3: disconnect after 2 of 5 bytes
        base = rx_n;
        r0 = src_rd[1];
        push_pkt(1, 8'h10, 5);
        wait_pop(1, r0 + 2, 50);
        MAIN_OPEN_ACK = 1'b0;
        tick(1);
        check("t3 drop pulse", 32'(DROP_ERR), 1);
        wait_pop(1, r0 + 5, 50);
        tick(3);
        check("t3 discard no tx", 32'(rx_n - base), 2);
        check("t3 drop count", 32'(drop_n), 1);
        check("t3 grant released", 32'(GRANT), 0);
        r0 = src_rd[0];
        push_pkt(0, 8'h0D, 1);
        tick(10);
        check("t3 no grant offline", 32'(GRANT), 0);
        check("t3 src0 stalled", 32'(src_rd[0]), 32'(r0));
        MAIN_OPEN_ACK = 1'b1;
        wait_drain(100);
        check("t3 after reconnect", 32'(rx_buf[rx_n - 1]), 32'h0D);

        // 4: close request mid-packet
        base = rx_n;
        r0 = src_rd[2];
        push_pkt(2, 8'h20, 4);
        wait_pop(2, r0 + 1, 50);
        CLOSE_REQ = 1'b1;
        tick(1);
        check("t4 drop pulse", 32'(DROP_ERR), 1);
        check("t4 no early ack", 32'(CLOSE_ACK), 0);
        begin
            int k = 0;
            while (!CLOSE_ACK && k < 50) begin
                tick(1);
                k++;
            end
        end
        check("t4 close ack", 32'(CLOSE_ACK), 1);
        check("t4 drained", 32'(src_rd[2] - r0), 4);
        check("t4 rx count", 32'(rx_n - base), 1);
        push_pkt(0, 8'h0E, 1);
        tick(5);
        check("t4 ack held", 32'(CLOSE_ACK), 1);
        check("t4 no grant in close", 32'(GRANT), 0);
        CLOSE_REQ = 1'b0;
        tick(1);
        check("t4 ack dropped", 32'(CLOSE_ACK), 0);
        wait_drain(100);
        check("t4 drop count", 32'(drop_n), 2);

        // 5: granted source 1 stalls for TO_US ticks
        push_pkt(1, 8'h15, 2);
        begin
            int k = 0;
            while (GRANT != 4'b0010 && k < 50) begin
                tick(1);
                k++;
            end
        end
        check("t5 grant src1", 32'(GRANT), 32'h2);
        src_hold[1] = 1'b1;
        tick(3);
        push_pkt(2, 8'h2A, 1);
        for (int p = 0; p < 2; p++) begin
            TIM_1US = 1'b1;
            tick(1);
            TIM_1US = 1'b0;
            tick(1);
        end
        tick(1);
        check("t5 no early timeout", 32'(to_err_n), 0);
        check("t5 still granted", 32'(GRANT), 32'h2);
        TIM_1US = 1'b1;
        tick(1);
        TIM_1US = 1'b0;
        check("t5 to pulse", 32'(TO_ERR), 1);
        check("t5 grant cleared", 32'(GRANT), 0);
        src_rd[1] = src_wr[1];
        src_hold[1] = 1'b0;
        wait_drain(100);
        check("t5 next grant", 32'(glog[g_n - 1]), 32'h4);
        check("t5 src2 byte", 32'(rx_buf[rx_n - 1]), 32'h2A);
        check("t5 to count", 32'(to_err_n), 1);

        // 6: counter wrap, then asynchronous reset mid-packet
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(2);
        base = rx_n;
        push_pkt(3, 8'h40, 20);
        wait_drain(200);
        check("t6 rx count", 32'(rx_n - base), 20);
        check("t6 last byte", 32'(rx_buf[rx_n - 1]), 32'h53);
        check("t6 cnt wrap", 32'(TX_BYTE_CNT), 4);
        r0 = src_rd[0];
        push_pkt(0, 8'h60, 10);
        wait_pop(0, r0 + 3, 50);
        d0 = drop_n;
        #2;
        RST = 1'b1;
        #1;
        check("t6 async grant", 32'(GRANT), 0);
        check("t6 async ready", 32'(SRC_READY), 0);
        check("t6 async tx_wr", 32'(TX_WR), 0);
        check("t6 async tx_data", 32'(TX_DATA), 0);
        check("t6 async cnt", 32'(TX_BYTE_CNT), 0);
        src_rd[0] = src_wr[0];
        tick(2);
        RST = 1'b0;
        tick(3);
        check("t6 no drop on reset", 32'(drop_n), 32'(d0));
        check("t6 idle after reset", 32'(GRANT), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
